// File: rtl/updown_counter_param_if.sv
// Signal bundle for updown_counter_param: enable, buttons and load inputs plus count/status outputs.
// The master side drives the controls; the slave side is the counter itself.
interface updown_counter_param_if #(
    parameter int WIDTH = 7
);
    logic             en;
    logic             up;
    logic             down;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] number;
    logic             dir;
    logic             at_max;
    logic             at_min;
    logic             wrap_pulse;

    modport master (
        output en, up, down, load, load_val,
        input  number, dir, at_max, at_min, wrap_pulse
    );

    modport slave (
        input  en, up, down, load, load_val,
        output number, dir, at_max, at_min, wrap_pulse
    );
endinterface

// File: rtl/updown_counter_param.sv
// Bounded up/down counter whose direction is chosen by press-and-release of asynchronous buttons.
// Optional button filter: define UDC_DEBOUNCE_EN to debounce with a DB_CYCLES stability window.
module updown_counter_param #(
    parameter int WIDTH     = 7,
    parameter int MIN_VAL   = 0,
    parameter int MAX_VAL   = 100,
    parameter int WRAP      = 1,
    parameter int DB_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    updown_counter_param_if.slave bus
);

`ifdef UDC_DEBOUNCE_EN
    localparam int DB_EN = 1;
`else
    localparam int DB_EN = 0;
`endif
    localparam int DB_WIN = DB_CYCLES * DB_EN;

    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH:0]   MIN_E = {1'b0, MIN_W};
    localparam logic [WIDTH:0]   MAX_E = {1'b0, MAX_W};
    localparam logic [WIDTH:0]   ONE_E = {{WIDTH{1'b0}}, 1'b1};

    typedef enum logic {
        S_DOWN = 1'b0,
        S_UP   = 1'b1
    } dir_state_e;

    // Bit 0 carries the up button, bit 1 the down button.
    logic [1:0] btn_s;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] level_s;
    logic [1:0] prev_q;
    logic [1:0] rel_s;

    dir_state_e       state_q;
    dir_state_e       state_d;
    logic             hold_evt_s;
    logic [WIDTH-1:0] number_q;
    logic [WIDTH-1:0] number_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             at_max_q;
    logic             at_min_q;

    // Returns {bound_hit, next_value}; arithmetic is one bit wider than the count.
    function automatic logic [WIDTH:0] step_up(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] sum;
        sum = {1'b0, v} + ONE_E;
        if (sum > MAX_E) begin
            step_up = {1'b1, (WRAP != 0) ? MIN_W : MAX_W};
        end else begin
            step_up = {1'b0, sum[WIDTH-1:0]};
        end
    endfunction

    function automatic logic [WIDTH:0] step_down(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] diff;
        diff = {1'b0, v} - ONE_E;
        if ({1'b0, v} <= MIN_E) begin
            step_down = {1'b1, (WRAP != 0) ? MAX_W : MIN_W};
        end else begin
            step_down = {1'b0, diff[WIDTH-1:0]};
        end
    endfunction

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        if ({1'b0, v} < MIN_E) begin
            clamp_load = MIN_W;
        end else if ({1'b0, v} > MAX_E) begin
            clamp_load = MAX_W;
        end else begin
            clamp_load = v;
        end
    endfunction

    assign btn_s = {bus.down, bus.up};

    // Two-flop synchronizer and release-edge history for both buttons
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            prev_q  <= 2'b00;
        end else begin
            sync1_q <= btn_s;
            sync2_q <= sync1_q;
            prev_q  <= level_s;
        end
    end

    generate
        if (DB_WIN > 0) begin : g_debounce
            localparam int            CW   = $clog2(DB_WIN + 1);
            localparam logic [CW-1:0] LAST = CW'(DB_WIN - 1);
            for (genvar i = 0; i < 2; i++) begin : g_btn
                logic [CW-1:0] stable_cnt_q;
                logic          level_q;

                // Accept a new level only after DB_WIN consecutive differing samples
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        stable_cnt_q <= {CW{1'b0}};
                        level_q      <= 1'b0;
                    end else if (sync2_q[i] == level_q) begin
                        stable_cnt_q <= {CW{1'b0}};
                    end else if (stable_cnt_q == LAST) begin
                        stable_cnt_q <= {CW{1'b0}};
                        level_q      <= sync2_q[i];
                    end else begin
                        stable_cnt_q <= stable_cnt_q + CW'(1);
                    end
                end

                assign level_s[i] = level_q;
            end
        end else begin : g_no_debounce
            assign level_s = sync2_q;
        end
    endgenerate

    assign rel_s = prev_q & ~level_s;

    // Direction transitions; simultaneous releases cancel and freeze the count
    always_comb begin
        state_d    = state_q;
        hold_evt_s = 1'b0;
        if (rel_s[0] && rel_s[1]) begin
            hold_evt_s = 1'b1;
        end else if (rel_s[1] && (state_q == S_UP)) begin
            state_d = S_DOWN;
        end else if (rel_s[0] && (state_q == S_DOWN)) begin
            state_d = S_UP;
        end else begin
            state_d = state_q;
        end
    end

    // Next count: load beats enable; a direction change steps in the new direction at once
    always_comb begin
        number_d = number_q;
        wrap_d   = 1'b0;
        if (bus.load) begin
            number_d = clamp_load(bus.load_val);
        end else if (!bus.en) begin
            number_d = number_q;
        end else if (hold_evt_s) begin
            number_d = number_q;
        end else if (state_d == S_UP) begin
            {wrap_d, number_d} = step_up(number_q);
        end else begin
            {wrap_d, number_d} = step_down(number_q);
        end
    end

    // Direction FSM, count value and its status flags, all registered together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_UP;
            number_q <= MIN_W;
            wrap_q   <= 1'b0;
            at_max_q <= 1'b0;
            at_min_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            number_q <= number_d;
            wrap_q   <= wrap_d;
            at_max_q <= (number_d == MAX_W);
            at_min_q <= (number_d == MIN_W);
        end
    end

    assign bus.number     = number_q;
    assign bus.dir        = (state_q == S_UP);
    assign bus.at_max     = at_max_q;
    assign bus.at_min     = at_min_q;
    assign bus.wrap_pulse = wrap_q;

endmodule
